// File: rtl/fir1_pkg.sv
// rtl/fir1_pkg.sv - shared defaults and saturation helper for the 4-tap FIR
package fir1_pkg;

  localparam int DW_DEF = 8;
  localparam int CW_DEF = 8;
  localparam int TAPS   = 4;

  localparam int H0_DEF = 1;
  localparam int H1_DEF = 2;
  localparam int H2_DEF = 2;
  localparam int H3_DEF = 1;

  // Working width for the scaled accumulator before clamping.
  localparam int MAX_W = 64;

  // Clamp a wide signed value to the signed range of a dw-bit word.
  function automatic logic signed [MAX_W-1:0] saturate(
    input logic signed [MAX_W-1:0] val,
    input int                      dw
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/fir1_delay_line.sv
// rtl/fir1_delay_line.sv - parameterized-depth sample shift register
module fir1_delay_line #(
  parameter int DW    = 8,
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         d_i,
  output logic [DEPTH*DW-1:0]   taps_o
);

  logic [DW-1:0] stage_q [DEPTH];

  // Shift a new sample in every edge; stage 0 holds the most recent one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Flatten the stages onto the tap bus, stage i at bits [i*DW +: DW].
  always_comb begin
    taps_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      taps_o[i*DW +: DW] = stage_q[i];
    end
  end

endmodule

// File: rtl/fir1_filter.sv
// rtl/fir1_filter.sv - 4-tap direct-form FIR with rounding and saturation
module fir1_filter
  import fir1_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int H0    = H0_DEF,
  parameter int H1    = H1_DEF,
  parameter int H2    = H2_DEF,
  parameter int H3    = H3_DEF,
  parameter int SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_x,
  output logic [DW-1:0] o_y
);

  // Four products of DW x CW bits summed need two extra bits of headroom.
  localparam int ACC_W = DW + CW + 2;

  localparam logic signed [CW-1:0] C0 = CW'(H0);
  localparam logic signed [CW-1:0] C1 = CW'(H1);
  localparam logic signed [CW-1:0] C2 = CW'(H2);
  localparam logic signed [CW-1:0] C3 = CW'(H3);

  // Half-LSB of the shifted result, added so the shift rounds half up.
  localparam logic signed [MAX_W-1:0] RND =
    (SHIFT > 0) ? (64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 64'sd0;

  logic [(TAPS-1)*DW-1:0] taps;

  logic signed [DW-1:0]    x0, x1, x2, x3;
  logic signed [ACC_W-1:0] acc;
  logic signed [MAX_W-1:0] acc_ext;
  logic signed [MAX_W-1:0] scaled;
  logic        [DW-1:0]    y_d;
  logic        [DW-1:0]    y_q;

  fir1_delay_line #(
    .DW    (DW),
    .DEPTH (TAPS - 1)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .d_i    (i_x),
    .taps_o (taps)
  );

  // Multiply-accumulate, round, scale and clamp the current window.
  always_comb begin
    x0      = signed'(i_x);
    x1      = signed'(taps[0*DW +: DW]);
    x2      = signed'(taps[1*DW +: DW]);
    x3      = signed'(taps[2*DW +: DW]);
    acc     = ACC_W'(C0) * ACC_W'(x0)
            + ACC_W'(C1) * ACC_W'(x1)
            + ACC_W'(C2) * ACC_W'(x2)
            + ACC_W'(C3) * ACC_W'(x3);
    acc_ext = MAX_W'(acc);
    scaled  = (acc_ext + RND) >>> SHIFT;
    y_d     = DW'(saturate(scaled, DW));
  end

  // Output register: reset clears it, otherwise it takes the filtered sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign o_y = y_q;

endmodule

// File: tb/tb_fir1_filter.sv
// tb/tb_fir1_filter.sv - scoreboard bench for fir1_filter
module tb_fir1_filter;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] x_a = '0;
  logic signed [7:0] x_b = '0;
  logic signed [7:0] y_a;
  logic signed [7:0] y_b;

  bit chk_a = 1'b0;
  bit chk_b = 1'b0;

  int exp_a[$];
  int exp_b[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir1_filter dut_a (
    .clk (clk),
    .rst (rst),
    .i_x (x_a),
    .o_y (y_a)
  );

  fir1_filter #(
    .H0    (1),
    .H1    (1),
    .H2    (1),
    .H3    (1),
    .SHIFT (2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .i_x (x_b),
    .o_y (y_b)
  );

  // One clock: drive inputs on the falling edge and queue what should appear
  // on o_y after the following rising edge.
  task automatic step(input logic r,
                      input int xa, input int ea, input bit ca,
                      input int xb, input int eb, input bit cb);
    @(negedge clk);
    rst   = r;
    x_a   = xa[7:0];
    x_b   = xb[7:0];
    chk_a = ca;
    chk_b = cb;
    if (ca) exp_a.push_back(ea);
    if (cb) exp_b.push_back(eb);
  endtask

  task automatic a_only(input logic r, input int xa, input int ea);
    step(r, xa, ea, 1'b1, 0, 0, 1'b0);
  endtask

  // Monitor: capture which stream is due at the rising edge, compare on the falling edge.
  initial begin
    bit fa, fb;
    int e;
    forever begin
      @(posedge clk);
      fa = chk_a;
      fb = chk_b;
      @(negedge clk);
      if (fa) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL y_a: output with empty queue, actual %0d", y_a);
        end else begin
          e = exp_a.pop_front();
          if (int'(y_a) != e) begin
            errors++;
            $display("FAIL y_a: actual %0d expected %0d", y_a, e);
          end
        end
      end
      if (fb) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL y_b: output with empty queue, actual %0d", y_b);
        end else begin
          e = exp_b.pop_front();
          if (int'(y_b) != e) begin
            errors++;
            $display("FAIL y_b: actual %0d expected %0d", y_b, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state on both instances, with nonzero input that must be ignored.
    step(1'b1, 55, 0, 1'b0, 55, 0, 1'b0);
    step(1'b1, 77, 0, 1'b1, 77, 0, 1'b1);

    // Impulse response.
    a_only(1'b0, 1, 1);
    a_only(1'b0, 0, 2);
    a_only(1'b0, 0, 2);
    a_only(1'b0, 0, 1);
    a_only(1'b0, 0, 0);

    // Mixed-sign sequence.
    a_only(1'b0,  1,  1);
    a_only(1'b0, -6, -4);
    a_only(1'b0, 10,  0);
    a_only(1'b0,  2, 11);
    a_only(1'b0, -4, 14);
    a_only(1'b0,  0,  6);
    a_only(1'b0,  0, -6);
    a_only(1'b0,  0, -4);
    a_only(1'b0,  0,  0);

    // Positive saturation: acc 127, 381, 635, 762.
    for (int i = 0; i < 4; i++) a_only(1'b0, 127, 127);

    // Clear history, then negative saturation: acc -128, -384, -640, -768.
    a_only(1'b1, 99, 0);
    for (int i = 0; i < 4; i++) a_only(1'b0, -128, -128);

    // Reset mid-stream discards history.
    a_only(1'b1, 0, 0);
    a_only(1'b0,  1,  1);
    a_only(1'b0, -6, -4);
    a_only(1'b0, 10,  0);
    a_only(1'b1, 33,  0);
    a_only(1'b0,  2,  2);
    a_only(1'b0, -4,  0);

    // Rounding on the SHIFT=2 unit-coefficient instance.
    step(1'b1, 0, 0, 1'b1, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1, 3, 1, 1'b1);
    step(1'b0, 0, 0, 1'b1, 3, 2, 1'b1);
    step(1'b0, 0, 0, 1'b1, 3, 2, 1'b1);
    step(1'b0, 0, 0, 1'b1, 3, 3, 1'b1);
    step(1'b0, 0, 0, 1'b1, 3, 3, 1'b1);

    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL drain: leftover a=%0d b=%0d expected 0 0", exp_a.size(), exp_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir1_filter.md
FIR1_FILTER -- requirements
Module: fir1_filter

Interface
REQ-001 The block SHALL expose parameter DW, default 8, as the input/output sample width (two's complement).
REQ-002 The block SHALL expose parameter CW, default 8, as the signed coefficient width.
REQ-003 The block SHALL expose parameters H0, H1, H2, H3, defaults 1, 2, 2, 1, as the signed tap coefficients for x[n], x[n-1], x[n-2], x[n-3].
REQ-004 The block SHALL expose parameter SHIFT, default 0, as the right-shift (0..15) applied to the accumulator before saturation.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port i_x, input, DW bits: signed input sample, sampled every rising edge (no valid strobe).
REQ-008 The block SHALL have port o_y, output, DW bits: signed filtered output, registered.

Function
REQ-009 The block SHALL implement a 4-tap direct-form FIR: acc = H0*x[n] + H1*x[n-1] + H2*x[n-2] + H3*x[n-3], with all operands signed.
REQ-010 x[n] SHALL be i_x at the current edge; x[n-1..n-3] SHALL come from a 3-stage delay line that shifts i_x in on every non-reset edge.
REQ-011 The accumulator SHALL be DW+CW+2 bits wide, sign-extended, and SHALL never overflow internally.
REQ-012 If SHIFT>0, the block SHALL add 2^(SHIFT-1) to acc and then shift it arithmetically right by SHIFT (round half up); if SHIFT=0, acc SHALL pass through unchanged.
REQ-013 The scaled result SHALL saturate to [-2^(DW-1), 2^(DW-1)-1], i.e. [-128, 127] by default; it SHALL never wrap.
REQ-014 o_y SHALL register the saturated result on the same edge that samples i_x, giving a latency of 1 clock from i_x to o_y.
REQ-015 The filter SHALL accept a new sample every cycle, with no stall and no bubbles.

Reset
REQ-016 While rst=1 at a rising edge, all three delay-line registers and o_y SHALL clear to 0, and i_x SHALL be ignored.
REQ-017 On the first edge with rst=0, the block SHALL behave as if all prior samples were 0.
REQ-018 Asserting rst mid-stream SHALL discard all history, and o_y SHALL read 0 on the following cycle.

Structure
REQ-019 A package fir1_pkg SHALL hold the default DW, CW and the tap count (4), the default coefficient constants, and a saturate function.
REQ-020 The block SHALL contain one sub-module, fir1_delay_line: a parameterized-depth, DW-wide shift register with synchronous reset.
REQ-021 The multiply-accumulate, rounding and saturation logic SHALL be combinational in fir1_filter and feed only the o_y register.

Verification
REQ-022 Impulse test: after reset, drive i_x = 1, 0, 0, 0, 0 -> o_y SHALL read 1, 2, 2, 1, 0 on successive cycles, each one cycle after its input.
REQ-023 Mixed-sign test: drive i_x = 1, -6, 10, 2, -4, then 0 -> o_y SHALL read 1, -4, 0, 11, 14, 6, -6, -4, 0.
REQ-024 Positive saturation test: hold i_x = 127 -> o_y SHALL read 127, 127, 127, 127 (acc reaches 762 and clamps); negative saturation test: hold i_x = -128 -> o_y SHALL read -128 steady.
REQ-025 Reset mid-stream test: during REQ-023, assert rst for 1 cycle after the sample 10 -> o_y SHALL read 0, and the next inputs 2, -4 SHALL yield 2, 0.
REQ-026 Rounding test: with SHIFT=2 and H0..H3 = 1, 1, 1, 1, drive i_x = 3 constant -> o_y SHALL read 1 (acc 3 -> 5>>2), 2 (6 -> 8>>2), 2 (9 -> 11>>2), 3 (12 -> 14>>2).
